ps2_device_tx: RTL

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_device_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_device_tx
// Description : PS/2 device-to-host byte transmitter with open-drain lines.
//               Optional macro PS2DEV_INHIBIT_RETRY_EN resends after inhibit.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
    parameter int CLK_HALF    = 2000,
    parameter int IDLE_CYCLES = 2500
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       TxDone,
    output logic       TxAbort,
    inout  wire        PS2Clk,
    inout  wire        PS2Data
);

    localparam int c_half_w = $clog2(CLK_HALF + 1);
    localparam int c_idle_w = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_half_w-1:0] c_half_last = c_half_w'(CLK_HALF - 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_CYCLES - 1);
    localparam logic [3:0]          c_last_bit  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_HIGH     = 3'd2,
        S_LOW      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    logic [7:0]            r_byte;
    logic [3:0]            r_bit_idx;
    logic [c_half_w-1:0]   r_cnt;
    logic [c_idle_w-1:0]   r_idle_cnt;
    logic                  r_clk_oe;
    logic                  r_dat_oe;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_abort;
    logic                  r_clk_s1;
    logic                  r_clk_s2;
    logic                  r_dat_s1;
    logic                  r_dat_s2;

    logic [10:0]           w_frame;
    logic [3:0]            w_bit_next;

    // Wire order, index 0 first: start, data LSB first, odd parity, stop.
    assign w_frame    = {1'b1, ~^r_byte, r_byte, 1'b0};
    assign w_bit_next = r_bit_idx + 4'd1;

    // Lines are only ever pulled low; the host pull-ups provide the high level.
    assign PS2Clk  = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2Data = r_dat_oe ? 1'b0 : 1'bz;

    assign TxReady = r_ready;
    assign TxDone  = r_done;
    assign TxAbort = r_abort;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= PS2Clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2Data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_byte     <= 8'd0;
            r_bit_idx  <= 4'd0;
            r_cnt      <= '0;
            r_idle_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (TxValid && r_ready) begin
                        r_byte     <= TxData;
                        r_idle_cnt <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= S_WAIT_BUS;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT_BUS: begin
                    // A host holding either line low (inhibit or RTS) keeps us here.
                    if (r_clk_s2 && r_dat_s2) begin
                        if (r_idle_cnt == c_idle_last) begin
                            r_idle_cnt <= '0;
                            r_cnt      <= '0;
                            r_bit_idx  <= 4'd0;
                            r_dat_oe   <= ~w_frame[0];
                            r_state    <= S_HIGH;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (!r_clk_s2) begin
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b0;
                            r_abort  <= 1'b1;
`ifdef PS2DEV_INHIBIT_RETRY_EN
                            r_idle_cnt <= '0;
                            r_state    <= S_WAIT_BUS;
`else
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_clk_oe <= 1'b1;
                            r_state  <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (r_bit_idx == c_last_bit) begin
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_bit_idx <= w_bit_next;
                            r_clk_oe  <= 1'b0;
                            r_dat_oe  <= ~w_frame[w_bit_next];
                            r_state   <= S_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
